rs_single_error_corrector: RTL and testbench
============================================

Name: rs_single_error_corrector

Overview:
- Stage directly downstream of the RS(18,16) syndrome computation.
- Accepts a received codeword with its two syndromes S1 and S2, and locates a single symbol error by a serial search over positions 0..N-1.
- Corrects the faulty symbol and presents the corrected codeword plus status through a valid/ready handshake.
- Field is GF(2^8), primitive polynomial 0x11D, alpha = 0x02. Symbol i sits at v[8i+7:8i]. S1 = sum v_i*alpha^i, S2 = sum v_i*alpha^(2i).

Parameters:
- N, 18, codeword length in symbols.
- SYMBOL_WIDTH, 8, bits per symbol.
- POS_WIDTH, 5, width of the position counter and of err_pos.

Ports:
- clk  in  1  single clock; all logic is synchronous to its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  codeword and syndromes are valid.
- in_ready  out  1  block can accept a codeword.
- v_in  in  N*SYMBOL_WIDTH  received codeword.
- s1  in  SYMBOL_WIDTH  syndrome S1.
- s2  in  SYMBOL_WIDTH  syndrome S2.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- v_out  out  N*SYMBOL_WIDTH  corrected codeword.
- corrected  out  1  one symbol was corrected.
- uncorrectable  out  1  error pattern cannot be corrected.
- err_pos  out  POS_WIDTH  index of the corrected symbol.
- err_val  out  SYMBOL_WIDTH  error magnitude XORed into that symbol.

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- While rst is high:
  - state=IDLE, j=0, X=Y=0x01;
  - all outputs 0, including in_ready, v_out, corrected, uncorrectable, err_pos, err_val;
  - in_ready rises in the first cycle after rst falls.
- Reset mid-operation: the in-flight codeword is abandoned and no output is produced.
- Three states: IDLE, SEARCH, OUT. in_ready=1 only in IDLE; out_valid=1 only in OUT.
- IDLE, on in_valid: latch v_in, s1, s2 into internal registers, then:
  - s1==0 and s2==0: go to OUT with corrected=0, uncorrectable=0, v_out=v_in.
  - exactly one of s1/s2 zero: go to OUT with uncorrectable=1, v_out=v_in unchanged.
  - otherwise: go to SEARCH with j=0, X=0x01 (alpha^j), Y=0x01 (alpha^-j).
- SEARCH, each cycle, compare GF_mul(s1,X) with s2:
  - Match: set symbol j ^= GF_mul(s1,Y), err_pos=j, err_val=GF_mul(s1,Y), corrected=1; go to OUT.
  - No match and j<N-1: j<=j+1, X<=GF_mul(X,0x02), Y<=GF_mul(Y,0x8E). 0x8E is alpha^-1.
  - No match and j==N-1: go to OUT with uncorrectable=1 and v_out unmodified.
- Latency, for a codeword accepted in cycle t:
  - zero or degenerate syndromes: out_valid at t+1;
  - error at position j: out_valid at t+2+j;
  - search exhausted: out_valid at t+1+N.
- OUT: all outputs are held stable until out_ready=1 while out_valid=1. After that cycle, return to IDLE; in_ready=1 in the next cycle.
  - out_ready high on entry to OUT: one-cycle pulse.
  - in_valid is ignored outside IDLE.
- Status encoding: corrected and uncorrectable are never both 1. err_pos and err_val are 0 unless corrected=1.
- Multiplications use the codebase GF_Multiplier; additions use GF_Adder (XOR).
- Scope: one outstanding codeword; no pipelining across codewords.

Test Plan:
- Zero syndromes: v_in arbitrary, s1=0x00, s2=0x00, accepted at t -> out_valid at t+1, v_out==v_in, corrected=0, uncorrectable=0.
- Error at position 3: v_in all zero except v_in[31:24]=0x05, s1=0x28, s2=0x5D -> out_valid at t+5, v_out all zero, corrected=1, err_pos=3, err_val=0x05.
- Error at last position: v_in all zero except v_in[143:136]=0x01, s1=0x98, s2=0x4E -> out_valid at t+19, err_pos=17, err_val=0x01, v_out all zero.
- Uncorrectable patterns:
  - s1=0x01, s2=0x00 -> out_valid at t+1, uncorrectable=1, v_out==v_in;
  - s1=0x01, s2=0x2D (alpha^18, position out of range) -> out_valid at t+19, uncorrectable=1.
- Backpressure: position-3 case with out_ready low for 5 cycles after out_valid, in_valid held high with a new codeword -> outputs stable, in_ready=0, second codeword accepted only in the cycle after the handshake completes.
- Reset mid-search: rst high for 1 cycle at j=2 of the position-17 case -> all outputs 0 during reset, no out_valid ever, in_ready=1 the cycle after rst falls, next codeword processed normally.

Source files
------------

// File: rtl/rs_single_error_corrector.sv
// RS(18,16) single-symbol corrector: serial Chien-style search over positions using S1/S2.
// Latency 1 cycle (zero/degenerate syndromes), 2+j (error at j), 1+N (exhausted); output held until out_ready.
module rs_single_error_corrector #(
    parameter int N            = 18,
    parameter int SYMBOL_WIDTH = 8,
    parameter int POS_WIDTH    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*SYMBOL_WIDTH-1:0]    v_in,
    input  logic [SYMBOL_WIDTH-1:0]      s1,
    input  logic [SYMBOL_WIDTH-1:0]      s2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*SYMBOL_WIDTH-1:0]    v_out,
    output logic                         corrected,
    output logic                         uncorrectable,
    output logic [POS_WIDTH-1:0]         err_pos,
    output logic [SYMBOL_WIDTH-1:0]      err_val
);

    typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

    localparam logic [SYMBOL_WIDTH-1:0] PRIM_LO   = SYMBOL_WIDTH'(8'h1D);
    localparam logic [SYMBOL_WIDTH-1:0] ONE       = SYMBOL_WIDTH'(8'h01);
    localparam logic [SYMBOL_WIDTH-1:0] ALPHA     = SYMBOL_WIDTH'(8'h02);
    localparam logic [SYMBOL_WIDTH-1:0] ALPHA_INV = SYMBOL_WIDTH'(8'h8E);
    localparam logic [POS_WIDTH-1:0]    LAST_POS  = POS_WIDTH'(N - 1);

    function automatic logic [SYMBOL_WIDTH-1:0] gf_add(
        input logic [SYMBOL_WIDTH-1:0] a,
        input logic [SYMBOL_WIDTH-1:0] b
    );
        return a ^ b;
    endfunction

    // Shift-and-add multiply modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [SYMBOL_WIDTH-1:0] gf_mul(
        input logic [SYMBOL_WIDTH-1:0] a,
        input logic [SYMBOL_WIDTH-1:0] b
    );
        logic [SYMBOL_WIDTH-1:0] p;
        logic [SYMBOL_WIDTH-1:0] t;
        p = '0;
        t = a;
        for (int k = 0; k < SYMBOL_WIDTH; k++) begin
            if (b[k]) p = gf_add(p, t);
            t = t[SYMBOL_WIDTH-1] ? ((t << 1) ^ PRIM_LO) : (t << 1);
        end
        return p;
    endfunction

    state_t                     r_state;
    state_t                     w_next;
    logic [N*SYMBOL_WIDTH-1:0]  r_v;
    logic [SYMBOL_WIDTH-1:0]    r_s1;
    logic [SYMBOL_WIDTH-1:0]    r_s2;
    logic [POS_WIDTH-1:0]       r_j;
    logic [SYMBOL_WIDTH-1:0]    r_x;
    logic [SYMBOL_WIDTH-1:0]    r_y;
    logic                       r_corrected;
    logic                       r_uncorr;
    logic [POS_WIDTH-1:0]       r_err_pos;
    logic [SYMBOL_WIDTH-1:0]    r_err_val;

    logic                       w_s1_zero;
    logic                       w_s2_zero;
    logic                       w_match;
    logic                       w_last;
    logic [SYMBOL_WIDTH-1:0]    w_s1x;
    logic [SYMBOL_WIDTH-1:0]    w_eval;
    logic [SYMBOL_WIDTH-1:0]    w_x_next;
    logic [SYMBOL_WIDTH-1:0]    w_y_next;

    assign w_s1_zero = (s1 == '0);
    assign w_s2_zero = (s2 == '0);
    // With X = alpha^j, S1*X == S2 exactly when the single error sits at j.
    assign w_s1x     = gf_mul(r_s1, r_x);
    assign w_eval    = gf_mul(r_s1, r_y);
    assign w_match   = (w_s1x == r_s2);
    assign w_last    = (r_j == LAST_POS);
    assign w_x_next  = gf_mul(r_x, ALPHA);
    assign w_y_next  = gf_mul(r_y, ALPHA_INV);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_s1_zero || w_s2_zero) w_next = OUT;
                    else                        w_next = SEARCH;
                end
            end
            SEARCH: begin
                if (w_match || w_last) w_next = OUT;
            end
            OUT: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_j         <= '0;
            r_x         <= ONE;
            r_y         <= ONE;
            r_corrected <= 1'b0;
            r_uncorr    <= 1'b0;
            r_err_pos   <= '0;
            r_err_val   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_v         <= v_in;
                        r_s1        <= s1;
                        r_s2        <= s2;
                        r_j         <= '0;
                        r_x         <= ONE;
                        r_y         <= ONE;
                        r_corrected <= 1'b0;
                        r_uncorr    <= w_s1_zero ^ w_s2_zero;
                        r_err_pos   <= '0;
                        r_err_val   <= '0;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        for (int i = 0; i < N; i++) begin
                            if (r_j == POS_WIDTH'(i))
                                r_v[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] <=
                                    gf_add(r_v[i*SYMBOL_WIDTH +: SYMBOL_WIDTH], w_eval);
                        end
                        r_corrected <= 1'b1;
                        r_err_pos   <= r_j;
                        r_err_val   <= w_eval;
                    end else if (w_last) begin
                        r_uncorr    <= 1'b1;
                    end else begin
                        r_j         <= r_j + 1'b1;
                        r_x         <= w_x_next;
                        r_y         <= w_y_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (r_state == IDLE) && !rst;
    assign out_valid     = (r_state == OUT);
    assign v_out         = r_v;
    assign corrected     = r_corrected;
    assign uncorrectable = r_uncorr;
    assign err_pos       = r_err_pos;
    assign err_val       = r_err_val;

endmodule

// File: tb/tb_rs_single_error_corrector.sv
// Directed-vector bench for rs_single_error_corrector: table of codewords plus backpressure and reset sequences.
module tb_rs_single_error_corrector;

    localparam int N  = 18;
    localparam int SW = 8;
    localparam int PW = 5;
    localparam int VW = N * SW;
    localparam logic [VW-1:0] PAT_A = 144'h0123456789abcdeffedcba98765432100f1e;
    localparam logic [VW-1:0] PAT_B = 144'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [VW-1:0] v_in = '0;
    logic [SW-1:0] s1 = '0;
    logic [SW-1:0] s2 = '0;
    logic          in_ready;
    logic          out_valid;
    logic [VW-1:0] v_out;
    logic          corrected;
    logic          uncorrectable;
    logic [PW-1:0] err_pos;
    logic [SW-1:0] err_val;

    int n_cmp = 0;
    int n_err = 0;

    rs_single_error_corrector #(.N(N), .SYMBOL_WIDTH(SW), .POS_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .v_in(v_in), .s1(s1), .s2(s2),
        .out_valid(out_valid), .out_ready(out_ready),
        .v_out(v_out), .corrected(corrected), .uncorrectable(uncorrectable),
        .err_pos(err_pos), .err_val(err_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] v;
        logic [SW-1:0] s1;
        logic [SW-1:0] s2;
        int            lat;
        logic [VW-1:0] ev;
        logic          ec;
        logic          eu;
        logic [PW-1:0] ep;
        logic [SW-1:0] ee;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k);
        int   cyc;
        logic busy;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready_idle", k), in_ready, 1);
        v_in     = tbl[k].v;
        s1       = tbl[k].s1;
        s2       = tbl[k].s2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc  = 1;
        busy = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) busy = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d_latency", k), cyc, tbl[k].lat);
        chk($sformatf("v%0d_busy_in_ready", k), {busy, in_ready}, 0);
        chk($sformatf("v%0d_v_out", k), v_out, tbl[k].ev);
        chk($sformatf("v%0d_corrected", k), corrected, tbl[k].ec);
        chk($sformatf("v%0d_uncorrectable", k), uncorrectable, tbl[k].eu);
        chk($sformatf("v%0d_err_pos", k), err_pos, tbl[k].ep);
        chk($sformatf("v%0d_err_val", k), err_val, tbl[k].ee);
        @(negedge clk);
        chk($sformatf("v%0d_return_idle", k), {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int   cyc;
        logic seen;

        // Expected syndromes/positions hand-derived from alpha powers in GF(2^8)/0x11D.
        tbl[0] = '{PAT_A, 8'h00, 8'h00, 1, PAT_A, 1'b0, 1'b0, 5'd0, 8'h00};
        tbl[1] = '{(144'h05 << 24), 8'h28, 8'h5D, 5, '0, 1'b1, 1'b0, 5'd3, 8'h05};
        tbl[2] = '{(144'h01 << 136), 8'h98, 8'h4E, 19, '0, 1'b1, 1'b0, 5'd17, 8'h01};
        tbl[3] = '{PAT_B, 8'h01, 8'h00, 1, PAT_B, 1'b0, 1'b1, 5'd0, 8'h00};
        tbl[4] = '{PAT_A, 8'h01, 8'h2D, 19, PAT_A, 1'b0, 1'b1, 5'd0, 8'h00};
        tbl[5] = '{PAT_B, 8'h00, 8'h37, 1, PAT_B, 1'b0, 1'b1, 5'd0, 8'h00};
        tbl[6] = '{PAT_A, 8'h5A, 8'h5A, 2, PAT_A ^ 144'h5A, 1'b1, 1'b0, 5'd0, 8'h5A};
        tbl[7] = '{(144'h01 << 72), 8'h3A, 8'h2D, 11, '0, 1'b1, 1'b0, 5'd9, 8'h01};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_handshake", {in_ready, out_valid}, 2'b00);
        chk("reset_v_out", v_out, '0);
        chk("reset_status", {corrected, uncorrectable, err_pos, err_val}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);

        for (int k = 0; k < 8; k++) run_vec(k);

        // Backpressure: result held 5 cycles while a second codeword waits on in_valid
        @(negedge clk);
        out_ready = 1'b0;
        v_in = tbl[1].v; s1 = tbl[1].s1; s2 = tbl[1].s2;
        in_valid = 1'b1;
        @(negedge clk);
        v_in = PAT_B; s1 = 8'h00; s2 = 8'h00;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", cyc, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d_status", i),
                {out_valid, in_ready, corrected, uncorrectable, err_pos, err_val},
                {1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 8'h05});
            chk($sformatf("bp_hold%0d_v_out", i), v_out, '0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("bp_release_valid", out_valid, 1);
        @(negedge clk);
        chk("bp_idle_gap", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_valid", {out_valid, corrected, uncorrectable}, 3'b100);
        chk("bp_second_v_out", v_out, PAT_B);
        @(negedge clk);
        chk("bp_second_done", out_valid, 0);

        // Reset during search at j=2 of a position-17 codeword
        @(negedge clk);
        v_in = PAT_A; s1 = 8'h98; s2 = 8'h4E;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_handshake", {in_ready, out_valid}, 2'b00);
        chk("midrst_v_out", v_out, '0);
        chk("midrst_status", {corrected, uncorrectable, err_pos, err_val}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready_after", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_output", seen, 0);
        run_vec(1);
        run_vec(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
